// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the word returned on a failed fetch, and the wait-counter width.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [31:0] NOP   = 32'h00000000;
   localparam int          CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// SIZE x 32 instruction storage: one synchronous write port for program load,
// one asynchronous read port that the responder samples when entering RESP.
module imem_array #(
   parameter int SIZE  = 1024,
   parameter int IDX_W = 10
) (
   input  logic             clock,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem [SIZE];

   // Contents are deliberately not reset; the boot loader owns initialisation.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch-path instruction memory: valid/ready request, WAIT wait states, one
// registered response pulse per request, plus a write-only program-load port.
module imem_responder
   import imem_pkg::*;
#(
   parameter int SIZE = 1024,
   parameter int WAIT = 2
) (
   input  logic        clock,
   input  logic        start,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   output logic [31:0] resp_instr,
   output logic        resp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_ready depends only on the state, never on req_valid.

   localparam int          IDX_W  = $clog2(SIZE);
   localparam logic [29:0] SIZE_W = 30'(SIZE);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [IDX_W-1:0] idx_q, rd_idx;
   logic             err_q, rd_err, req_err, ld_ok, enter_resp;
   logic [31:0]      rd_data;

   assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= SIZE_W);
   assign ld_ok     = ld_en && (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < SIZE_W);
   assign req_ready = (state == ST_IDLE);
   assign state_dbg = state;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (WAIT == 0) begin
                  state_n = ST_RESP;
               end else begin
                  state_n = ST_WAIT;
                  cnt_n   = CNT_W'(WAIT);
               end
            end
         end
         ST_WAIT: begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_n = ST_RESP;
         end
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // With no wait states RESP is entered on the accept edge itself, so the
   // read must use the live request rather than the latched one.
   assign enter_resp = (state_n == ST_RESP);
   assign rd_idx     = (state == ST_IDLE) ? req_addr[IDX_W+1:2] : idx_q;
   assign rd_err     = (state == ST_IDLE) ? req_err : err_q;

   always_ff @(posedge clock or negedge start) begin
      if (!start) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
         resp_valid <= 1'b0;
         resp_instr <= NOP;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         resp_valid <= enter_resp;
         busy       <= (state_n != ST_IDLE);
         if (state == ST_IDLE && req_valid) begin
            idx_q <= req_addr[IDX_W+1:2];
            err_q <= req_err;
         end
         if (enter_resp) begin
            resp_instr <= rd_err ? NOP : rd_data;
            resp_err   <= rd_err;
         end
      end
   end

   imem_array #(
      .SIZE  (SIZE),
      .IDX_W (IDX_W)
   ) u_array (
      .clock (clock),
      .we    (ld_ok),
      .waddr (ld_addr[IDX_W+1:2]),
      .wdata (ld_data),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the fetch path: accepts word fetch requests from the instruction fetch unit over a valid/ready handshake, inserts a fixed number of wait states, and returns one registered instruction word per request. Also provides a write-only program-load port so the bench or a boot loader can fill the memory before or while the core runs. Sits between the fetch unit and the instruction storage, replacing a zero-latency combinational instruction memory.

## Interface
- SIZE, 1024, memory depth in 32-bit words (power of two, 16..65536)
- WAIT, 2, wait states inserted per fetch (0..15)
- clock  in  1  system clock, rising edge
- start  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  byte address of the fetch
- resp_valid  out  1  one-cycle pulse: resp_instr/resp_err valid
- resp_instr  out  32  fetched instruction
- resp_err  out  1  request was misaligned or out of range
- ld_en  in  1  program-load write strobe
- ld_addr  in  32  byte address of the load word
- ld_data  in  32  word to store
- busy  out  1  request in flight (state != IDLE)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Accept when req_valid&&req_ready: latch word index req_addr[31:2] and error flag. Error = req_addr[1:0]!=0 or req_addr[31:2] >= SIZE. Next state WAIT with cnt=WAIT, or RESP directly if WAIT==0.
- WAIT: req_ready=0; cnt decrements each edge; at the edge where cnt==1, go to RESP.
- On the edge that enters RESP: resp_instr <= err ? 32'h00000000 : mem[index]; resp_err <= err.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, next state IDLE. No back-to-back acceptance; minimum request spacing WAIT+2 cycles.
- resp_instr and resp_err hold their values after the pulse until the next response.
- Load port: on any edge with ld_en=1 in any state, mem[ld_addr[31:2]] <= ld_data. Loads with ld_addr[1:0]!=0 or index >= SIZE are dropped silently.
- Load/fetch collision: read on RESP entry is read-before-write; a load on that same edge to the same index is not visible in this response; a load on any earlier edge is.
- Width rules: index is log2(SIZE) bits; upper address bits only used for the range check.

## Timing
- Reset (start=0, asynchronous): state=IDLE, cnt=0, resp_valid=0, resp_instr=0, resp_err=0, busy=0, req_ready=1 after release. Memory contents are not reset.
- Reset mid-operation: in-flight request is discarded, no resp_valid is issued.
- Latency: request accepted at edge t; resp_valid high in the cycle following edge t+WAIT; consumer samples at edge t+WAIT+1.
- req_ready is a pure function of state (no combinational path from req_valid).
- resp_valid, resp_instr, resp_err, busy all registered.

## Structure
- Package imem_pkg: state encoding (IDLE/WAIT/RESP), NOP constant 32'h00000000, CNT_W=4.
- One sub-module imem_array: SIZE x 32 storage, one synchronous write port (load), one read port sampled on RESP entry; no reset of contents.
- Top holds FSM, wait counter, address/error checks.

## Test plan
- Load mem[3]=32'h8C220004 via ld_addr=0x0C, WAIT=2; fetch req_addr=0x0C at edge t -> resp_valid only in cycle after t+2, resp_instr=32'h8C220004, resp_err=0.
- WAIT=0 build: fetch 0x00 after loading 32'h20010005 -> resp_valid in cycle after accept edge; req_ready low exactly one cycle.
- Fetch req_addr=0x0000_0006 -> resp_err=1, resp_instr=0; fetch req_addr=SIZE*4 -> resp_err=1, resp_instr=0.
- During WAIT, load index 5 with 32'hDEADBEEF while fetching 0x14 (old 32'h11111111): load one edge before RESP entry -> 32'hDEADBEEF; load on RESP-entry edge -> 32'h11111111.
- Hold req_valid=1 continuously for 3 requests, WAIT=2 -> accepts every 4 cycles, exactly 3 resp_valid pulses.
- Assert start=0 during WAIT, release -> no resp_valid, all outputs 0, req_ready=1, previously loaded word still readable.
